// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, flow-control characters,
// FSM state encoding and frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [7:0] XON_DEFAULT  = 8'h11;
  localparam logic [7:0] XOFF_DEFAULT = 8'h13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } uart_state_e;

  function automatic int frame_cycles(
    input int cpb,
    input int dbits,
    input int par,
    input int stops
  );
    int p;
    p = (par != PARITY_NONE) ? 1 : 0;
    return (1 + dbits + p + stops) * cpb;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts down from CLOCKS_PER_BAUD-1, wraps to give the
// end-of-bit strobe, and flags the half-bit point for start sampling.
module uart_bit_timer #(
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic clear_i,
  output logic mid_o,
  output logic end_o
);

  localparam int W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [W-1:0] RELOAD =
    W'(CLOCKS_PER_BAUD - 1);
  localparam logic [W-1:0] MID =
    W'(CLOCKS_PER_BAUD - CLOCKS_PER_BAUD / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      run_d = 1'b0;
      cnt_d = RELOAD;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = RELOAD;
    end else if (run_q) begin
      cnt_d = (cnt_q == '0) ? RELOAD
                            : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RELOAD;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign mid_o = run_q && (cnt_q == MID);
  assign end_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART engine with parity, frame/parity error flags and
// optional XON/XOFF pause of the transmitter driven by the rx stream.
module uart_core
  import uart_pkg::*;
#(
  parameter int         CLOCKS_PER_BAUD = 104,
  parameter int         DATA_BITS       = 8,
  parameter int         PARITY          = PARITY_NONE,
  parameter int         STOP_BITS       = 1,
  parameter int         FLOW_CTRL       = 0,
  parameter logic [7:0] XOFF_CHAR       = XOFF_DEFAULT,
  parameter logic [7:0] XON_CHAR        = XON_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 tx_paused_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o
);

  localparam bit PAR_EN =
    (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam int LOW = (DATA_BITS < 8) ? DATA_BITS : 8;

  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       rx_fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  uart_state_e          rx_state_q;
  logic [3:0]           rx_cnt_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_perr_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_ferr_q;
  logic                 rx_perr_out_q;
  logic                 paused_q;
  logic                 rx_tstart, rx_tclear;
  logic                 rx_mid, rx_end;
  logic [7:0]           rx_low8;

  uart_bit_timer #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_rx_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .start_i(rx_tstart),
    .clear_i(rx_tclear),
    .mid_o  (rx_mid),
    .end_o  (rx_end)
  );

  // Restarting at mid-start puts every later wrap mid-bit.
  always_comb begin
    rx_tstart = 1'b0;
    rx_tclear = 1'b0;
    unique case (rx_state_q)
      S_IDLE:  rx_tstart = rx_fall;
      S_START: begin
        if (rx_mid) begin
          rx_tstart = !rx_s;
          rx_tclear = rx_s;
        end
      end
      S_STOP:  rx_tclear = rx_end;
      default: ;
    endcase
  end

  always_comb begin
    rx_low8 = '0;
    for (int i = 0; i < LOW; i++) begin
      rx_low8[i] = rx_sh_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_sh_q       <= '0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_perr_out_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (rx_state_q)
        S_IDLE: begin
          if (rx_fall) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_mid) begin
            rx_state_q <= rx_s ? S_IDLE : S_DATA;
            rx_cnt_q   <= '0;
            rx_perr_q  <= 1'b0;
          end
        end
        S_DATA: begin
          if (rx_end) begin
            rx_sh_q  <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_q <= rx_cnt_q + 4'd1;
            if (rx_cnt_q == DLAST)
              rx_state_q <= PAR_EN ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (rx_end) begin
            rx_perr_q  <= (^rx_sh_q ^ rx_s) != PAR_ODD;
            rx_state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_end) begin
            rx_state_q    <= S_IDLE;
            rx_valid_q    <= 1'b1;
            rx_data_q     <= rx_sh_q;
            rx_ferr_q     <= !rx_s;
            rx_perr_out_q <= rx_perr_q;
            // Only clean frames may steer the transmitter.
            if (FLOW_CTRL != 0 && rx_s && !rx_perr_q) begin
              if (rx_low8 == XOFF_CHAR)
                paused_q <= 1'b1;
              else if (rx_low8 == XON_CHAR)
                paused_q <= 1'b0;
            end
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  uart_state_e          tx_state_q;
  logic [3:0]           tx_cnt_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 tx_accept;
  logic                 tx_tclear;
  logic                 tx_end;
  logic                 tx_mid_unused;

  assign tx_ready_o = (tx_state_q == S_IDLE) && !paused_q;
  assign tx_busy_o  = (tx_state_q != S_IDLE);
  assign tx_accept  = tx_valid_i && tx_ready_o;
  assign tx_tclear  = (tx_state_q == S_STOP) && tx_end
                      && (tx_cnt_q == SLAST);

  uart_bit_timer #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_tx_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .start_i(tx_accept),
    .clear_i(tx_tclear),
    .mid_o  (tx_mid_unused),
    .end_o  (tx_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      unique case (tx_state_q)
        S_IDLE: begin
          if (tx_accept) begin
            tx_state_q <= S_START;
            tx_q       <= 1'b0;
            tx_sh_q    <= tx_data_i;
            tx_par_q   <= (^tx_data_i) ^ PAR_ODD;
          end
        end
        S_START: begin
          if (tx_end) begin
            tx_state_q <= S_DATA;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_cnt_q   <= '0;
          end
        end
        S_DATA: begin
          if (tx_end) begin
            if (tx_cnt_q == DLAST) begin
              tx_cnt_q <= '0;
              if (PAR_EN) begin
                tx_state_q <= S_PAR;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_cnt_q <= tx_cnt_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (tx_end) begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
          end
        end
        S_STOP: begin
          if (tx_end) begin
            if (tx_cnt_q == SLAST)
              tx_state_q <= S_IDLE;
            else
              tx_cnt_q <= tx_cnt_q + 4'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_o            = tx_q;
  assign tx_paused_o     = paused_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_frame_err_o  = rx_frame_err_q_w();
  assign rx_parity_err_o = rx_perr_out_q;

  function automatic logic rx_frame_err_q_w();
    return rx_ferr_q;
  endfunction

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: 8N1 with flow control, 8E1 loopback,
// and 8O1 driven by hand, all at 4 clocks per bit.
module tb_uart_core;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, tx_a;
  logic [7:0] txd_a = '0;
  logic       txv_a = 1'b0;
  logic       rdy_a, busy_a, pau_a;
  logic [7:0] rxd_a;
  logic       rxv_a, fe_a, pe_a;

  logic       tx_b;
  logic [7:0] txd_b = '0;
  logic       txv_b = 1'b0;
  logic       rdy_b, busy_b, pau_b;
  logic [7:0] rxd_b;
  logic       rxv_b, fe_b, pe_b;

  logic       rx_c = 1'b1, tx_c;
  logic [7:0] txd_c = '0;
  logic       txv_c = 1'b0;
  logic       rdy_c, busy_c, pau_c;
  logic [7:0] rxd_c;
  logic       rxv_c, fe_c, pe_c;

  uart_core #(
    .CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FLOW_CTRL(1),
    .XOFF_CHAR(8'h13), .XON_CHAR(8'h11)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .rx_i(rx_a), .tx_o(tx_a),
    .tx_data_i(txd_a), .tx_valid_i(txv_a),
    .tx_ready_o(rdy_a), .tx_busy_o(busy_a),
    .tx_paused_o(pau_a), .rx_data_o(rxd_a),
    .rx_valid_o(rxv_a), .rx_frame_err_o(fe_a),
    .rx_parity_err_o(pe_a)
  );

  uart_core #(
    .CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FLOW_CTRL(0),
    .XOFF_CHAR(8'h13), .XON_CHAR(8'h11)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .rx_i(tx_b), .tx_o(tx_b),
    .tx_data_i(txd_b), .tx_valid_i(txv_b),
    .tx_ready_o(rdy_b), .tx_busy_o(busy_b),
    .tx_paused_o(pau_b), .rx_data_o(rxd_b),
    .rx_valid_o(rxv_b), .rx_frame_err_o(fe_b),
    .rx_parity_err_o(pe_b)
  );

  uart_core #(
    .CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FLOW_CTRL(0),
    .XOFF_CHAR(8'h13), .XON_CHAR(8'h11)
  ) dut_c (
    .clock(clk), .reset_n(rst_n), .rx_i(rx_c), .tx_o(tx_c),
    .tx_data_i(txd_c), .tx_valid_i(txv_c),
    .tx_ready_o(rdy_c), .tx_busy_o(busy_c),
    .tx_paused_o(pau_c), .rx_data_o(rxd_c),
    .rx_valid_o(rxv_c), .rx_frame_err_o(fe_c),
    .rx_parity_err_o(pe_c)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;

  always @(negedge clk) if (rxv_a) cnt_a++;
  always @(negedge clk) if (rxv_b) cnt_b++;
  always @(negedge clk) if (rxv_c) cnt_c++;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic vsel(input int sel);
    unique case (1'b1)
      (sel == 0): return rxv_a;
      (sel == 1): return rxv_b;
      default:    return rxv_c;
    endcase
  endfunction

  function automatic logic [39:0] exp_wave(
    input logic [7:0] d
  );
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, d, 1'b0};
    for (int k = 0; k < 40; k++) r[k] = f[k / 4];
    return r;
  endfunction

  task automatic hold();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_c = v;
  endtask

  task automatic drive_rx(
    input int         sel,
    input logic [7:0] d,
    input bit         par_en,
    input logic       pbit,
    input logic       stopb
  );
    set_rx(sel, 1'b0);
    hold();
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      hold();
    end
    if (par_en) begin
      set_rx(sel, pbit);
      hold();
    end
    set_rx(sel, stopb);
    hold();
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_pulse(
    input  int sel,
    input  int max,
    output int n
  );
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (vsel(sel)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic cap_a(
    output logic [39:0] w,
    output int          low
  );
    low = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k < 40) w[k] = tx_a;
      if (!rdy_a) low++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] w;
    int low, n, c0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_rdy", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_pau", pau_a, 0);
    chk("rst_rxv", rxv_a, 0);
    chk("rst_rxd", rxd_a, 0);
    chk("rst_err", {fe_a, pe_a}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    txd_a = 8'hA5;
    txv_a = 1'b1;
    @(posedge clk);
    #1 txv_a = 1'b0;
    txd_a = 8'hFF;
    cap_a(w, low);
    chk("tx_wave_a5", w, exp_wave(8'hA5));
    chk("tx_rdy_low", low, 40);
    chk("tx_rdy_back", rdy_a, 1);
    chk("tx_busy_end", busy_a, 0);

    @(posedge clk);
    #1 txd_b = 8'h3C;
    txv_b = 1'b1;
    c0 = cnt_b;
    @(posedge clk);
    #1 txv_b = 1'b0;
    wait_pulse(1, 100, n);
    chk("lb_lat", n, 46);
    repeat (10) @(negedge clk);
    chk("lb_cnt", cnt_b - c0, 1);
    chk("lb_data", rxd_b, 8'h3C);
    chk("lb_err", {fe_b, pe_b}, 0);

    @(posedge clk);
    #1 c0 = cnt_a;
    drive_rx(0, 8'h55, 0, 1'b0, 1'b0);
    wait_pulse(0, 20, n);
    chk("fe_seen", n > 0, 1);
    chk("fe_data", rxd_a, 8'h55);
    chk("fe_flag", fe_a, 1);
    chk("fe_perr", pe_a, 0);
    repeat (8) @(posedge clk);
    chk("fe_cnt", cnt_a - c0, 1);

    #1 c0 = cnt_a;
    rx_a = 1'b0;
    @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (60) @(posedge clk);
    chk("glitch_none", cnt_a - c0, 0);
    #1 drive_rx(0, 8'h5A, 0, 1'b0, 1'b1);
    wait_pulse(0, 20, n);
    chk("after_glitch_data", rxd_a, 8'h5A);
    chk("after_glitch_err", {fe_a, pe_a}, 0);
    repeat (4) @(posedge clk);

    #1 drive_rx(1, 8'h07, 1, 1'b1, 1'b1);
    wait_pulse(2, 20, n);
    chk("odd_bad_seen", n > 0, 1);
    chk("odd_bad_perr", pe_c, 1);
    chk("odd_bad_data", rxd_c, 8'h07);
    chk("odd_bad_fe", fe_c, 0);
    repeat (4) @(posedge clk);
    #1 drive_rx(1, 8'h06, 1, 1'b1, 1'b1);
    wait_pulse(2, 20, n);
    chk("odd_ok_perr", pe_c, 0);
    chk("odd_ok_data", rxd_c, 8'h06);
    repeat (4) @(posedge clk);

    #1 drive_rx(0, 8'h13, 0, 1'b0, 1'b0);
    wait_pulse(0, 20, n);
    chk("xoff_ferr_fe", fe_a, 1);
    chk("xoff_ferr_pau", pau_a, 0);
    repeat (4) @(posedge clk);

    #1;
    fork
      drive_rx(0, 8'h13, 0, 1'b0, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1 txd_a = 8'hC3;
        txv_a = 1'b1;
        @(posedge clk);
        #1 txv_a = 1'b0;
        cap_a(w, low);
      end
    join
    chk("xoff_wave_c3", w, exp_wave(8'hC3));
    chk("xoff_pau", pau_a, 1);
    chk("xoff_rdy", rdy_a, 0);
    chk("xoff_busy", busy_a, 0);
    txd_a = 8'h77;
    txv_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("xoff_hold", busy_a, 0);
    chk("xoff_line", tx_a, 1);
    @(posedge clk);
    #1 drive_rx(0, 8'h11, 0, 1'b0, 1'b1);
    wait_pulse(0, 20, n);
    chk("xon_seen", n > 0, 1);
    chk("xon_pau", pau_a, 0);
    chk("xon_rdy", rdy_a, 1);
    @(negedge clk);
    chk("xon_go", busy_a, 1);
    txv_a = 1'b0;
    repeat (50) @(posedge clk);

    #1;
    fork
      drive_rx(0, 8'h13, 0, 1'b0, 1'b1);
      begin
        repeat (38) @(posedge clk);
        #1 txd_a = 8'h5A;
        txv_a = 1'b1;
        @(posedge clk);
        #1 txv_a = 1'b0;
      end
    join
    wait_pulse(0, 20, n);
    chk("pre_rst_pau", pau_a, 1);
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy_a, 1);
    chk("pre_rst_tx", tx_a, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_rdy", rdy_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_pau", pau_a, 0);
    chk("mid_rst_rxd", rxd_a, 0);
    chk("mid_rst_flags", {rxv_a, fe_a, pe_a}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART engine: configurable baud divisor, data width, parity and stop bits, with receive error flags and optional XON/XOFF transmit flow control. It replaces ad-hoc rx/tx pairs with one block that board-level tops wrap with FIFOs and LED oneshots. XOFF/XON characters received from the host pause and resume the transmitter in hardware.

## Interface
- CLOCKS_PER_BAUD, 104, clock cycles per bit (104 = 115200 baud at 12 MHz); must be ≥ 4.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, transmitted stop bits, 1 or 2.
- FLOW_CTRL, 0, 1 enables XON/XOFF handling on the receive stream.
- XOFF_CHAR, 8'h13, byte that pauses tx; compared against the low 8 bits of received data.
- XON_CHAR, 8'h11, byte that resumes tx.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_i  in  1  serial input, asynchronous to clock.
- tx_o  out  1  serial output, idle high.
- tx_data_i  in  DATA_BITS  byte to send.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  transmitter accepts data this cycle.
- tx_busy_o  out  1  frame in progress.
- tx_paused_o  out  1  XOFF in effect.
- rx_data_o  out  DATA_BITS  last received data.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o and error flags valid.
- rx_frame_err_o  out  1  stop bit sampled low; qualified by rx_valid_o.
- rx_parity_err_o  out  1  parity mismatch; qualified by rx_valid_o; 0 when PARITY=0.

## Operation
- Reset: tx_o=1, tx_ready_o=1, tx_busy_o=0, tx_paused_o=0, rx_valid_o=0, rx_data_o=0, both error flags 0, both FSMs in IDLE. Reset is legal mid-frame. A partial tx frame is aborted with tx_o forced high immediately. A partial rx frame is discarded.
- rx_i passes through a 2-flop synchroniser (reset value 1). All rx logic uses the synchronised signal.
- RX FSM: IDLE → START on a synchronised falling edge. START waits CLOCKS_PER_BAUD/2 cycles and samples: high returns to IDLE (glitch, no output), low goes to DATA. DATA samples DATA_BITS bits LSB-first, one every CLOCKS_PER_BAUD cycles. Then PARITY (if enabled). Then STOP samples once and goes to IDLE. Only the first stop bit is checked.
- After the STOP sample, rx_valid_o pulses for exactly 1 cycle. Data and flags are updated and held until the next pulse. A frame error still delivers the data.
- Flow control (FLOW_CTRL=1):
  - A frame with no errors equal to XOFF_CHAR sets tx_paused_o.
  - A frame with no errors equal to XON_CHAR clears tx_paused_o.
  - These frames still pulse rx_valid_o. Consumers filter them.
  - A pause never truncates the frame in flight. It only blocks the next accept.
- TX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP (STOP_BITS×CLOCKS_PER_BAUD cycles) → IDLE.
- tx_ready_o = IDLE && !tx_paused_o. Data is accepted on tx_valid_i && tx_ready_o and latched. tx_data_i may change afterwards.
- Parity: odd means the data bits plus the parity bit contain an odd number of ones. Even means an even number.
- Baud counters are $clog2(CLOCKS_PER_BAUD) bits wide and reload at CLOCKS_PER_BAUD-1. The counter wrap is the only bit strobe.

## Timing
- TX latency: tx_o drops in the cycle after the accept cycle. tx_ready_o is 0 from that cycle onward.
- Each bit lasts exactly CLOCKS_PER_BAUD cycles.
- A frame is (1+DATA_BITS+P+STOP_BITS)×CLOCKS_PER_BAUD cycles, where P=1 if parity is enabled.
- tx_ready_o returns to 1 in the cycle after the final stop-bit cycle. Back-to-back frames have no idle gap.
- RX latency: rx_valid_o asserts 2 (synchroniser) + 1 (edge) + CLOCKS_PER_BAUD/2 + (DATA_BITS+P+1)×CLOCKS_PER_BAUD cycles after the falling edge of rx_i, then 1 cycle of registration.
- The RX FSM re-arms in IDLE right after the stop sample. It accepts a new start edge arriving half a bit later, which tolerates about 5% baud mismatch.
- Simultaneous XOFF and accept in the same cycle: the accept wins, that frame is sent, and the next accept is blocked.

## Structure
- Shared package uart_pkg:
  - parity constants PARITY_NONE/ODD/EVEN;
  - XON/XOFF defaults;
  - a function computing frame length.
- One natural sub-module: uart_bit_timer (counter with start/clear inputs, a mid-bit strobe and an end-of-bit strobe). It is instantiated once in rx and once in tx.

## Test plan
- CLOCKS_PER_BAUD=4, 8N1, send 8'hA5 → tx_o shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_ready_o low for 40 cycles.
- Loop tx_o to rx_i, 8E1, send 8'h3C → rx_valid_o pulses once, rx_data_o=8'h3C, both errors 0.
- Drive a 8'h55 frame with stop bit 0 → rx_valid_o pulses with rx_frame_err_o=1 and rx_data_o=8'h55.
- 8O1 with the parity bit inverted → rx_parity_err_o=1.
- Drive a 1-cycle low glitch on rx_i → no rx_valid_o, FSM back to IDLE.
- FLOW_CTRL=1:
  - receive 8'h13 mid-transmission → current frame completes, tx_ready_o stays 0, tx_paused_o=1;
  - receive 8'h11 → tx_ready_o=1 next cycle.
- Assert reset_n low mid-frame → tx_o=1 immediately and all outputs return to reset values.
